// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver: synchronizes and filters ps2c/ps2d, deserializes
// 11-bit frames and emits checked scan codes; bad or stalled frames are dropped.
module ps2_scan_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] scan_code,
  output logic       scan_done_tick,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for a start bit (only at a frame boundary)
  // DATA  | shifting data, parity and stop bits
  // CHECK | one cycle to validate stop/parity and emit exactly one pulse
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state_q, state_d;
  logic                    ps2c_meta_q, ps2c_meta_d, ps2c_sync_q, ps2c_sync_d;
  logic                    ps2d_meta_q, ps2d_meta_d, ps2d_sync_q, ps2d_sync_d;
  logic [FILTER_LEN-1:0]   filt_q, filt_d;
  logic                    fclk_q, fclk_d;
  logic [3:0]              pos_q, pos_d;
  logic [9:0]              shift_q, shift_d;
  logic [WD_W-1:0]         wdog_q, wdog_d;
  logic [7:0]              scan_code_q, scan_code_d;
  logic                    tick_q, tick_d, perr_q, perr_d, ferr_q, ferr_d, busy_q, busy_d;
  logic                    fall, expire;

  assign fall   = fclk_q & ~(|filt_q);
  assign expire = (wdog_q == WD_W'(1));

  always_comb begin
    ps2c_meta_d = ps2c;
    ps2c_sync_d = ps2c_meta_q;
    ps2d_meta_d = ps2d;
    ps2d_sync_d = ps2d_meta_q;
    filt_d      = {filt_q[FILTER_LEN-2:0], ps2c_sync_q};
    fclk_d      = fclk_q;
    if (&filt_q)        fclk_d = 1'b1;
    else if (~(|filt_q)) fclk_d = 1'b0;

    wdog_d = wdog_q;
    if (fall)                   wdog_d = WD_W'(TIMEOUT_CYCLES);
    else if (wdog_q != '0)      wdog_d = wdog_q - WD_W'(1);

    // Line position tracks frame boundaries even while disabled, so a frame
    // already in flight when rx_en rises is skipped up to its stop edge.
    pos_d = pos_q;
    if (fall) begin
      if (pos_q == 4'd0)       pos_d = ps2d_sync_q ? 4'd0 : 4'd1;
      else if (pos_q == 4'd10) pos_d = 4'd0;
      else                     pos_d = pos_q + 4'd1;
    end else if (expire) begin
      pos_d = 4'd0;
    end

    state_d     = state_q;
    shift_d     = shift_q;
    scan_code_d = scan_code_q;
    tick_d      = 1'b0;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && rx_en && pos_q == 4'd0) begin
          if (!ps2d_sync_q) begin
            state_d = DATA;
            shift_d = '0;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (fall) begin
          shift_d = {ps2d_sync_q, shift_q[9:1]};
          if (pos_q == 4'd10) state_d = CHECK;
        end else if (expire) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (shift_q[9] && (^shift_q[8:0])) begin
          scan_code_d = shift_q[7:0];
          tick_d      = 1'b1;
        end else if (!shift_q[9]) begin
          ferr_d = 1'b1;
        end else begin
          perr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rx_en) begin
      state_d     = IDLE;
      scan_code_d = scan_code_q;
      tick_d      = 1'b0;
      perr_d      = 1'b0;
      ferr_d      = 1'b0;
    end
    busy_d = (state_d == DATA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
      filt_q      <= '1;
      fclk_q      <= 1'b1;
      pos_q       <= '0;
      shift_q     <= '0;
      wdog_q      <= '0;
      scan_code_q <= 8'h00;
      tick_q      <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ps2c_meta_q <= ps2c_meta_d;
      ps2c_sync_q <= ps2c_sync_d;
      ps2d_meta_q <= ps2d_meta_d;
      ps2d_sync_q <= ps2d_sync_d;
      filt_q      <= filt_d;
      fclk_q      <= fclk_d;
      pos_q       <= pos_d;
      shift_q     <= shift_d;
      wdog_q      <= wdog_d;
      scan_code_q <= scan_code_d;
      tick_q      <= tick_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
    end
  end

  assign scan_code      = scan_code_q;
  assign scan_done_tick = tick_q;
  assign parity_err     = perr_q;
  assign frame_err      = ferr_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: table of frames, corner-case sequences,
// and random frames checked against a rule-level frame outcome model.
module tb_ps2_scan_rx;
  localparam int F    = 8;
  localparam int T    = 600;
  localparam int HALF = 60;

  logic       clk = 1'b0;
  logic       reset, ps2c, ps2d, rx_en;
  logic [7:0] scan_code;
  logic       scan_done_tick, parity_err, frame_err, busy;

  ps2_scan_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .scan_code(scan_code), .scan_done_tick(scan_done_tick),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the inactive edge.
  int n_tick = 0, n_perr = 0, n_ferr = 0, tick_cyc = 0, ferr_cyc = 0;
  always @(negedge clk) begin
    if (scan_done_tick) begin n_tick <= n_tick + 1; tick_cyc <= cyc; end
    if (parity_err) n_perr <= n_perr + 1;
    if (frame_err) begin n_ferr <= n_ferr + 1; ferr_cyc <= cyc; end
  end

  int checks = 0, failures = 0;
  int fall_cyc = 0;
  logic [7:0] model_code = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         et, ep, ef;
    logic [7:0] code;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    wait_cyc(HALF);
    ps2c = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2c = 1'b1;
  endtask

  function automatic logic [10:0] fbits(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic send_range(input logic [10:0] b, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(b[i]);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic p, input logic s,
                           input int et, input int ep, input int ef, input logic [7:0] code);
    int t0, p0, f0;
    t0 = n_tick; p0 = n_perr; f0 = n_ferr;
    send_range(fbits(d, p, s), 0, 10);
    ps2d = 1'b1;
    wait_cyc(F + 12);
    chk({tag, "_tick"}, n_tick - t0, et);
    chk({tag, "_perr"}, n_perr - p0, ep);
    chk({tag, "_ferr"}, n_ferr - f0, ef);
    chk({tag, "_code"}, int'(scan_code), int'(code));
    chk({tag, "_busy"}, int'(busy), 0);
    if (et == 1)
      chk({tag, "_latency_ok"}, int'((tick_cyc - fall_cyc) >= F + 2 && (tick_cyc - fall_cyc) <= F + 4), 1);
  endtask

  initial begin
    int t0, p0, f0, last, d;
    logic [7:0] rd;
    logic rp, rs;
    int kind, et, ep, ef;

    tbl[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
    tbl[1] = '{8'hF0, 1'b1, 1'b1, 1, 0, 0, 8'hF0};
    tbl[2] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
    tbl[3] = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h1C};
    tbl[4] = '{8'h32, 1'b0, 1'b1, 1, 0, 0, 8'h32};
    tbl[5] = '{8'h1C, 1'b0, 1'b0, 0, 0, 1, 8'h32};

    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1;
    wait_cyc(5);
    chk("rst_code", int'(scan_code), 0);
    chk("rst_tick", int'(scan_done_tick), 0);
    chk("rst_perr", int'(parity_err), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    wait_cyc(F + 5);

    for (int i = 0; i < 6; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].par, tbl[i].stop,
                tbl[i].et, tbl[i].ep, tbl[i].ef, tbl[i].code);

    // A lone high "start" bit in IDLE is a framing error.
    f0 = n_ferr;
    send_bit(1'b1);
    wait_cyc(F + 10);
    chk("bad_start_ferr", n_ferr - f0, 1);
    chk("bad_start_busy", int'(busy), 0);

    // Stall after start + 5 data bits.
    f0 = n_ferr;
    send_range(fbits(8'h1C, 1'b0, 1'b1), 0, 5);
    wait_cyc(F + 6);
    chk("stall_busy_mid", int'(busy), 1);
    last = fall_cyc;
    for (int i = 0; i < T + 200 && n_ferr == f0; i++) wait_cyc(1);
    wait_cyc(2);
    chk("stall_ferr", n_ferr - f0, 1);
    d = ferr_cyc - (last + F + 2);
    chk("stall_timing_ok", int'(d >= T - 1 && d <= T + 2), 1);
    chk("stall_busy_after", int'(busy), 0);
    run_frame("after_stall", 8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C);

    // Short ps2c glitches: idle, then mid-frame during a clock-high phase.
    t0 = n_tick; p0 = n_perr; f0 = n_ferr;
    ps2c = 1'b0; wait_cyc(F - 2); ps2c = 1'b1;
    wait_cyc(F + 10);
    chk("glitch_idle_ferr", n_ferr - f0, 0);
    chk("glitch_idle_busy", int'(busy), 0);
    send_range(fbits(8'h1C, 1'b0, 1'b1), 0, 3);
    wait_cyc(20);
    ps2c = 1'b0; wait_cyc(F - 2); ps2c = 1'b1;
    wait_cyc(20);
    send_range(fbits(8'h1C, 1'b0, 1'b1), 4, 10);
    ps2d = 1'b1;
    wait_cyc(F + 12);
    chk("glitch_mid_tick", n_tick - t0, 1);
    chk("glitch_mid_errs", (n_perr - p0) + (n_ferr - f0), 0);
    chk("glitch_mid_code", int'(scan_code), 8'h1C);

    // Enable rises mid-frame: the rest of that frame must be ignored.
    t0 = n_tick; p0 = n_perr; f0 = n_ferr;
    rx_en = 1'b0;
    send_range(fbits(8'h32, 1'b0, 1'b1), 0, 3);
    rx_en = 1'b1;
    send_range(fbits(8'h32, 1'b0, 1'b1), 4, 10);
    ps2d = 1'b1;
    wait_cyc(T + 50);
    chk("late_en_events", (n_tick - t0) + (n_perr - p0) + (n_ferr - f0), 0);
    chk("late_en_code", int'(scan_code), 8'h1C);
    run_frame("after_late_en", 8'h32, 1'b0, 1'b1, 1, 0, 0, 8'h32);

    // Async reset after the 4th data bit.
    send_range(fbits(8'hA5, 1'b1, 1'b1), 0, 4);
    wait_cyc(3);
    reset = 1'b1;
    #1;
    chk("midrst_code", int'(scan_code), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pulses", int'(scan_done_tick) + int'(parity_err) + int'(frame_err), 0);
    ps2c = 1'b1; ps2d = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(F + 5);
    model_code = 8'h00;

    // rx_en dropped during the stop bit.
    t0 = n_tick; p0 = n_perr; f0 = n_ferr;
    send_range(fbits(8'h1C, 1'b0, 1'b1), 0, 9);
    rx_en = 1'b0;
    send_range(fbits(8'h1C, 1'b0, 1'b1), 10, 10);
    wait_cyc(F + 12);
    chk("en_drop_events", (n_tick - t0) + (n_perr - p0) + (n_ferr - f0), 0);
    chk("en_drop_code", int'(scan_code), 0);
    rx_en = 1'b1;
    wait_cyc(10);
    run_frame("reenable", 8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C);
    model_code = 8'h1C;

    // Random frames vs. rule-level model.
    for (int i = 0; i < 16; i++) begin
      rd   = 8'($urandom);
      kind = int'($urandom_range(0, 3));
      rp   = ~(^rd);
      if (kind == 2) rp = ^rd;
      rs   = (kind == 3) ? 1'b0 : 1'b1;
      et = 0; ep = 0; ef = 0;
      if (!rs)                          ef = 1;
      else if (($countones({rd, rp}) % 2) == 1) begin et = 1; model_code = rd; end
      else                              ep = 1;
      run_frame($sformatf("rnd%0d", i), rd, rp, rs, et, ep, ef, model_code);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
